fb_console: RTL and testbench

Text-mode console writer driving the 80x30 character framebuffer write port (`fb_addr`/`fb_data`/`fb_we`) consumed by the VGA controller. Accepts a byte stream over a valid/ready handshake, interprets a small set of control characters, tracks the cursor, and sequences framebuffer writes, including line and full-screen clears. It gives any byte producer (CPU I/O port, UART bridge) terminal-style output without software address arithmetic.

---
 rtl/fb_console_pkg.sv | 24 ++
 rtl/fb_fill_engine.sv | 86 ++++++++
 rtl/fb_console.sv | 191 +++++++++++++++++++
 tb/tb_fb_console.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_console_pkg.sv
// fb_console_pkg: shared state type, control codes and default screen geometry
// for the text-mode console writer.
package fb_console_pkg;

  // Default geometry of the VGA text framebuffer
  localparam int         DEF_COLS       = 80;
  localparam int         DEF_ROWS       = 30;
  localparam int         DEF_ADDR_W     = 12;
  localparam logic [7:0] DEF_CLEAR_CHAR = 8'h20;

  // Control codes interpreted by the console
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_FF = 8'h0C;

  // Console sequencing state
  typedef enum logic [1:0] {
    CLR_SCREEN = 2'd0,
    IDLE       = 2'd1,
    CLR_LINE   = 2'd2
  } fb_console_state_t;

endpackage

// File: rtl/fb_fill_engine.sv
// fb_fill_engine: emits a run of consecutive fill-character writes starting at
// a given address. A start can either issue its first write on the same edge
// (start_now) or merely arm the run so writes begin on the following edge,
// which leaves the port free for a byte write on the start edge. done is high
// for one cycle after the final write has been issued.
module fb_fill_engine #(
  parameter int         ADDR_W    = 12,
  parameter int         LEN_W     = 12,
  parameter logic [7:0] FILL_CHAR = 8'h20,
  parameter int         RESET_LEN = 2400
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              start_now,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  start_len,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              done
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);

  logic              active_reg, active_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [LEN_W-1:0]  cnt_reg, cnt_next;
  logic [LEN_W-1:0]  len_reg, len_next;

  assign wr_data = FILL_CHAR;

  // Run control: launch, step the address/count, and retire when count hits length
  always_comb begin
    active_next = active_reg;
    addr_next   = addr_reg;
    cnt_next    = cnt_reg;
    len_next    = len_reg;
    wr_en       = 1'b0;
    wr_addr     = addr_reg;
    done        = 1'b0;
    if (start) begin
      active_next = 1'b1;
      len_next    = start_len;
      if (start_now) begin
        wr_en    = 1'b1;
        wr_addr  = start_addr;
        cnt_next = LEN_ONE;
        // Hold the address at the last cell of a one-write run
        addr_next = (start_len == LEN_ONE) ? start_addr : start_addr + ADDR_ONE;
      end else begin
        addr_next = start_addr;
        cnt_next  = '0;
      end
    end else if (active_reg) begin
      if (cnt_reg != len_reg) begin
        wr_en    = 1'b1;
        cnt_next = cnt_reg + LEN_ONE;
        // Never step past the final address of the run
        if (cnt_next != len_reg) begin
          addr_next = addr_reg + ADDR_ONE;
        end
      end else begin
        done        = 1'b1;
        active_next = 1'b0;
      end
    end
  end

  // Run registers; reset arms a full-screen run from address 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_reg <= 1'b1;
      addr_reg   <= '0;
      cnt_reg    <= '0;
      len_reg    <= LEN_W'(RESET_LEN);
    end else begin
      active_reg <= active_next;
      addr_reg   <= addr_next;
      cnt_reg    <= cnt_next;
      len_reg    <= len_next;
    end
  end

endmodule

// File: rtl/fb_console.sv
// fb_console: terminal-style byte stream to text framebuffer writer. Decodes
// LF/CR/BS/FF, tracks the cursor with a running row-base address and clears
// each newly entered row (or the whole screen) through fb_fill_engine.
module fb_console
  import fb_console_pkg::*;
#(
  parameter int         COLS       = DEF_COLS,
  parameter int         ROWS       = DEF_ROWS,
  parameter int         ADDR_W     = DEF_ADDR_W,
  parameter logic [7:0] CLEAR_CHAR = DEF_CLEAR_CHAR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        char_data,
  input  logic              char_valid,
  output logic              char_ready,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_data,
  output logic              fb_we,
  output logic [6:0]        cursor_col,
  output logic [4:0]        cursor_row,
  output logic              busy
);

  localparam int                CELLS     = COLS * ROWS;
  localparam int                LEN_W     = $clog2(CELLS + 1);
  localparam logic [6:0]        COL_LAST  = 7'(COLS - 1);
  localparam logic [4:0]        ROW_LAST  = 5'(ROWS - 1);
  localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
  localparam logic [LEN_W-1:0]  LINE_LEN  = LEN_W'(COLS);
  localparam logic [LEN_W-1:0]  SCREEN_LEN = LEN_W'(CELLS);

  fb_console_state_t state_reg, state_next;
  logic [6:0]        col_reg, col_next;
  logic [4:0]        row_reg, row_next;
  logic [ADDR_W-1:0] row_base_reg, row_base_next;

  logic              accept;
  logic [4:0]        wrap_row;
  logic [ADDR_W-1:0] wrap_base;
  logic              byte_we;
  logic [ADDR_W-1:0] byte_addr;
  logic [7:0]        byte_data;

  logic              fill_start;
  logic              fill_now;
  logic [ADDR_W-1:0] fill_base;
  logic [LEN_W-1:0]  fill_len;
  logic              fill_we;
  logic [ADDR_W-1:0] fill_addr;
  logic [7:0]        fill_data;
  logic              fill_done;

  assign char_ready = (state_reg == IDLE);
  assign busy       = (state_reg != IDLE);
  assign accept     = char_valid && char_ready;
  assign cursor_col = col_reg;
  assign cursor_row = row_reg;

  // Row below the cursor, wrapping from the last row back to row 0
  assign wrap_row  = (row_reg == ROW_LAST) ? 5'd0 : row_reg + 5'd1;
  assign wrap_base = (row_reg == ROW_LAST) ? '0 : row_base_reg + COLS_A;

  fb_fill_engine #(
    .ADDR_W    (ADDR_W),
    .LEN_W     (LEN_W),
    .FILL_CHAR (CLEAR_CHAR),
    .RESET_LEN (CELLS)
  ) u_fill (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (fill_start),
    .start_now  (fill_now),
    .start_addr (fill_base),
    .start_len  (fill_len),
    .wr_en      (fill_we),
    .wr_addr    (fill_addr),
    .wr_data    (fill_data),
    .done       (fill_done)
  );

  // Byte decode, cursor movement and clear-sequence launch
  always_comb begin
    state_next    = state_reg;
    col_next      = col_reg;
    row_next      = row_reg;
    row_base_next = row_base_reg;
    byte_we       = 1'b0;
    byte_addr     = row_base_reg + ADDR_W'(col_reg);
    byte_data     = char_data;
    fill_start    = 1'b0;
    fill_now      = 1'b0;
    fill_base     = wrap_base;
    fill_len      = LINE_LEN;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          case (char_data)
            CH_LF: begin
              // Clear of the new row starts on this very edge
              col_next      = '0;
              row_next      = wrap_row;
              row_base_next = wrap_base;
              fill_start    = 1'b1;
              fill_now      = 1'b1;
              state_next    = CLR_LINE;
            end
            CH_CR: begin
              col_next = '0;
            end
            CH_BS: begin
              if (col_reg != 7'd0) begin
                col_next  = col_reg - 7'd1;
                byte_we   = 1'b1;
                byte_addr = row_base_reg + ADDR_W'(col_reg - 7'd1);
                byte_data = CLEAR_CHAR;
              end
            end
            CH_FF: begin
              col_next      = '0;
              row_next      = '0;
              row_base_next = '0;
              fill_start    = 1'b1;
              fill_now      = 1'b1;
              fill_base     = '0;
              fill_len      = SCREEN_LEN;
              state_next    = CLR_SCREEN;
            end
            default: begin
              byte_we = 1'b1;
              if (col_reg < COL_LAST) begin
                col_next = col_reg + 7'd1;
              end else begin
                // The printable owns the port this edge; the clear follows
                col_next      = '0;
                row_next      = wrap_row;
                row_base_next = wrap_base;
                fill_start    = 1'b1;
                fill_now      = 1'b0;
                state_next    = CLR_LINE;
              end
            end
          endcase
        end
      end
      CLR_LINE, CLR_SCREEN: begin
        if (fill_done) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and cursor registers; reset starts a full-screen clear from home
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= CLR_SCREEN;
      col_reg      <= '0;
      row_reg      <= '0;
      row_base_reg <= '0;
    end else begin
      state_reg    <= state_next;
      col_reg      <= col_next;
      row_reg      <= row_next;
      row_base_reg <= row_base_next;
    end
  end

  // Registered write port: byte writes and fill writes never coincide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_we   <= 1'b0;
      fb_addr <= '0;
      fb_data <= '0;
    end else if (byte_we) begin
      fb_we   <= 1'b1;
      fb_addr <= byte_addr;
      fb_data <= byte_data;
    end else if (fill_we) begin
      fb_we   <= 1'b1;
      fb_addr <= fill_addr;
      fb_data <= fill_data;
    end else begin
      fb_we   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fb_console.sv
// tb_fb_console: directed self-checking bench for fb_console. Inputs change
// and outputs are sampled on the falling clock edge.
module tb_fb_console;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  char_data = 8'h00;
  logic        char_valid = 1'b0;
  logic        char_ready;
  logic [11:0] fb_addr;
  logic [7:0]  fb_data;
  logic        fb_we;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;

  int checks = 0;
  int errors = 0;

  fb_console dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .char_data  (char_data),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .fb_we      (fb_we),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Present one byte for one rising edge; returns at the following falling edge
  task automatic put(input logic [7:0] b);
    char_data  = b;
    char_valid = 1'b1;
    @(negedge clk);
    char_valid = 1'b0;
    $display("byte %02h -> we=%0d addr=%0d data=%02h cursor=(%0d,%0d)",
             b, fb_we, fb_addr, fb_data, cursor_row, cursor_col);
  endtask

  // Wait (bounded) until the console accepts bytes again
  task automatic wait_ready(input int limit);
    int n = 0;
    while (char_ready !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (char_ready !== 1'b1) begin
      $display("FAIL wait_ready char_ready=%0b after %0d cycles, want 1", char_ready, n);
      errors++;
    end
  endtask

  task automatic test_reset();
    bit bad = 0;
    rst_n = 1'b0;
    #12;
    checks++; if (fb_we !== 1'b0)   begin $display("FAIL rst_we got %0b want 0", fb_we); errors++; end
    checks++; if (fb_addr !== 12'd0) begin $display("FAIL rst_addr got %0d want 0", fb_addr); errors++; end
    checks++; if (fb_data !== 8'h00) begin $display("FAIL rst_data got %02h want 00", fb_data); errors++; end
    checks++; if (char_ready !== 1'b0) begin $display("FAIL rst_ready got %0b want 0", char_ready); errors++; end
    checks++; if (busy !== 1'b1)    begin $display("FAIL rst_busy got %0b want 1", busy); errors++; end
    checks++; if (cursor_col !== 7'd0 || cursor_row !== 5'd0) begin
      $display("FAIL rst_cursor got (%0d,%0d) want (0,0)", cursor_row, cursor_col); errors++; end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2400; i++) begin
      @(negedge clk);
      checks++;
      if (!bad && (fb_we !== 1'b1 || fb_addr !== 12'(i) || fb_data !== 8'h20 || char_ready !== 1'b0)) begin
        $display("FAIL init_fill cycle %0d got we=%0b addr=%0d data=%02h ready=%0b want we=1 addr=%0d data=20 ready=0",
                 i, fb_we, fb_addr, fb_data, char_ready, i);
        errors++;
        bad = 1;
      end
    end
    @(negedge clk);
    checks++; if (char_ready !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL init_done got ready=%0b busy=%0b want ready=1 busy=0", char_ready, busy); errors++; end
    checks++; if (fb_we !== 1'b0) begin $display("FAIL init_we_drop got %0b want 0", fb_we); errors++; end
    checks++; if (cursor_col !== 7'd0 || cursor_row !== 5'd0) begin
      $display("FAIL init_cursor got (%0d,%0d) want (0,0)", cursor_row, cursor_col); errors++; end
    $display("reset fill of 2400 cells finished");
  endtask

  task automatic test_stream();
    logic [7:0]  bytes  [4] = '{8'h41, 8'h42, 8'h0D, 8'h43};
    logic        e_we   [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [11:0] e_addr [4] = '{12'd0, 12'd1, 12'd1, 12'd0};
    logic [7:0]  e_data [4] = '{8'h41, 8'h42, 8'h42, 8'h43};
    logic [6:0]  e_col  [4] = '{7'd1, 7'd2, 7'd0, 7'd1};
    char_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      char_data = bytes[i];
      @(negedge clk);
      $display("stream byte %02h -> we=%0d addr=%0d data=%02h col=%0d", bytes[i], fb_we, fb_addr, fb_data, cursor_col);
      checks++;
      if (fb_we !== e_we[i] || fb_addr !== e_addr[i] || fb_data !== e_data[i]) begin
        $display("FAIL stream_write[%0d] got we=%0b addr=%0d data=%02h want we=%0b addr=%0d data=%02h",
                 i, fb_we, fb_addr, fb_data, e_we[i], e_addr[i], e_data[i]);
        errors++;
      end
      checks++;
      if (cursor_col !== e_col[i] || cursor_row !== 5'd0 || char_ready !== 1'b1) begin
        $display("FAIL stream_cursor[%0d] got (%0d,%0d) ready=%0b want (0,%0d) ready=1",
                 i, cursor_row, cursor_col, char_ready, e_col[i]);
        errors++;
      end
    end
    char_valid = 1'b0;
    @(negedge clk);
    checks++; if (fb_we !== 1'b0) begin $display("FAIL stream_we_pulse got %0b want 0", fb_we); errors++; end
  endtask

  task automatic test_line_wrap();
    bit bad = 0;
    put(8'h0D);
    checks++; if (fb_we !== 1'b0 || cursor_col !== 7'd0) begin
      $display("FAIL cr got we=%0b col=%0d want we=0 col=0", fb_we, cursor_col); errors++; end
    char_valid = 1'b1;
    for (int i = 0; i < 80; i++) begin
      char_data = 8'h61 + 8'(i % 26);
      @(negedge clk);
      checks++;
      if (!bad && (fb_we !== 1'b1 || fb_addr !== 12'(i) || fb_data !== 8'h61 + 8'(i % 26))) begin
        $display("FAIL wrap_print[%0d] got we=%0b addr=%0d data=%02h want we=1 addr=%0d data=%02h",
                 i, fb_we, fb_addr, fb_data, i, 8'h61 + 8'(i % 26));
        errors++;
        bad = 1;
      end
    end
    checks++; if (cursor_row !== 5'd1 || cursor_col !== 7'd0 || char_ready !== 1'b0) begin
      $display("FAIL wrap_cursor got (%0d,%0d) ready=%0b want (1,0) ready=0", cursor_row, cursor_col, char_ready); errors++; end
    char_data = 8'h5A;
    bad = 0;
    for (int j = 0; j < 80; j++) begin
      @(negedge clk);
      checks++;
      if (!bad && (fb_we !== 1'b1 || fb_addr !== 12'(80 + j) || fb_data !== 8'h20 || busy !== 1'b1)) begin
        $display("FAIL wrap_clear[%0d] got we=%0b addr=%0d data=%02h busy=%0b want we=1 addr=%0d data=20 busy=1",
                 j, fb_we, fb_addr, fb_data, busy, 80 + j);
        errors++;
        bad = 1;
      end
    end
    @(negedge clk);
    checks++; if (fb_we !== 1'b0 || char_ready !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL wrap_clear_end got we=%0b ready=%0b busy=%0b want 0,1,0", fb_we, char_ready, busy); errors++; end
    @(negedge clk);
    char_valid = 1'b0;
    checks++; if (fb_we !== 1'b1 || fb_addr !== 12'd80 || fb_data !== 8'h5A) begin
      $display("FAIL wrap_81st got we=%0b addr=%0d data=%02h want we=1 addr=80 data=5a", fb_we, fb_addr, fb_data); errors++; end
    checks++; if (cursor_row !== 5'd1 || cursor_col !== 7'd1) begin
      $display("FAIL wrap_81st_cursor got (%0d,%0d) want (1,1)", cursor_row, cursor_col); errors++; end
  endtask

  task automatic test_lf_last_row();
    bit bad = 0;
    int busy_cycles = 0;
    for (int n = 0; n < 28; n++) begin
      wait_ready(200);
      put(8'h0A);
    end
    wait_ready(200);
    checks++; if (cursor_row !== 5'd29 || cursor_col !== 7'd0) begin
      $display("FAIL lf_reach_29 got (%0d,%0d) want (29,0)", cursor_row, cursor_col); errors++; end
    put(8'h0A);
    checks++; if (cursor_row !== 5'd0 || cursor_col !== 7'd0) begin
      $display("FAIL lf_wrap_cursor got (%0d,%0d) want (0,0)", cursor_row, cursor_col); errors++; end
    for (int j = 0; j < 80; j++) begin
      if (j > 0) @(negedge clk);
      if (busy === 1'b1) busy_cycles++;
      checks++;
      if (!bad && (fb_we !== 1'b1 || fb_addr !== 12'(j) || fb_data !== 8'h20)) begin
        $display("FAIL lf_clear[%0d] got we=%0b addr=%0d data=%02h want we=1 addr=%0d data=20",
                 j, fb_we, fb_addr, fb_data, j);
        errors++;
        bad = 1;
      end
    end
    @(negedge clk);
    if (busy === 1'b1) busy_cycles++;
    checks++; if (busy_cycles !== 80) begin
      $display("FAIL lf_busy_len got %0d want 80", busy_cycles); errors++; end
    checks++; if (fb_we !== 1'b0 || char_ready !== 1'b1) begin
      $display("FAIL lf_end got we=%0b ready=%0b want we=0 ready=1", fb_we, char_ready); errors++; end
    put(8'h08);
    checks++; if (fb_we !== 1'b0 || cursor_col !== 7'd0 || cursor_row !== 5'd0) begin
      $display("FAIL bs_col0 got we=%0b cursor=(%0d,%0d) want we=0 (0,0)", fb_we, cursor_row, cursor_col); errors++; end
  endtask

  task automatic test_bs_ff();
    bit bad = 0;
    for (int n = 0; n < 3; n++) begin
      wait_ready(200);
      put(8'h0A);
    end
    wait_ready(200);
    for (int n = 0; n < 10; n++) put(8'h78);
    checks++; if (cursor_row !== 5'd3 || cursor_col !== 7'd10) begin
      $display("FAIL bs_setup got (%0d,%0d) want (3,10)", cursor_row, cursor_col); errors++; end
    put(8'h08);
    checks++; if (fb_we !== 1'b1 || fb_addr !== 12'd249 || fb_data !== 8'h20) begin
      $display("FAIL bs_write got we=%0b addr=%0d data=%02h want we=1 addr=249 data=20", fb_we, fb_addr, fb_data); errors++; end
    checks++; if (cursor_row !== 5'd3 || cursor_col !== 7'd9) begin
      $display("FAIL bs_cursor got (%0d,%0d) want (3,9)", cursor_row, cursor_col); errors++; end
    put(8'h0C);
    checks++; if (cursor_row !== 5'd0 || cursor_col !== 7'd0) begin
      $display("FAIL ff_cursor got (%0d,%0d) want (0,0)", cursor_row, cursor_col); errors++; end
    for (int j = 0; j < 2400; j++) begin
      if (j > 0) @(negedge clk);
      checks++;
      if (!bad && (fb_we !== 1'b1 || fb_addr !== 12'(j) || fb_data !== 8'h20 || busy !== 1'b1)) begin
        $display("FAIL ff_clear[%0d] got we=%0b addr=%0d data=%02h busy=%0b want we=1 addr=%0d data=20 busy=1",
                 j, fb_we, fb_addr, fb_data, busy, j);
        errors++;
        bad = 1;
      end
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || char_ready !== 1'b1 || fb_we !== 1'b0) begin
      $display("FAIL ff_end got busy=%0b ready=%0b we=%0b want 0,1,0", busy, char_ready, fb_we); errors++; end
  endtask

  task automatic test_reset_mid_clear();
    put(8'h0C);
    repeat (500) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (fb_we !== 1'b0 || fb_addr !== 12'd0 || fb_data !== 8'h00) begin
      $display("FAIL midrst_outputs got we=%0b addr=%0d data=%02h want 0,0,00", fb_we, fb_addr, fb_data); errors++; end
    checks++; if (busy !== 1'b1 || char_ready !== 1'b0) begin
      $display("FAIL midrst_state got busy=%0b ready=%0b want 1,0", busy, char_ready); errors++; end
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checks++;
      if (fb_we !== 1'b1 || fb_addr !== 12'(j) || fb_data !== 8'h20) begin
        $display("FAIL midrst_restart[%0d] got we=%0b addr=%0d data=%02h want we=1 addr=%0d data=20",
                 j, fb_we, fb_addr, fb_data, j);
        errors++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_line_wrap();
    test_lf_last_row();
    test_bs_ff();
    test_reset_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
